latch_dump_sequencer: RTL

Debug-side counterpart of the pipeline latch mux. On a start request it walks every valid latch-select code and drives it to the mux. It captures each returned 32-bit word and streams it as bytes over a valid/ready interface to the debug UART transmitter. One start produces one complete pipeline snapshot frame for the host.

---
 rtl/latch_dump_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/latch_dump_sequencer.sv
// Walks the latch-select code table, captures each returned word from the latch mux
// and streams it MSB-first as bytes over a valid/ready link to the debug UART.
module latch_dump_sequencer #(
  parameter bit         SEND_SOF  = 1'b1,
  parameter logic [7:0] SOF_BYTE  = 8'hA5,
  parameter int         NUM_CODES = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inStart,
  input  logic [31:0] inData,
  input  logic        inTxReady,
  output logic [6:0]  outControl,
  output logic [7:0]  outTxData,
  output logic        outTxValid,
  output logic        outBusy,
  output logic        outDone
);

  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CODES - 1);

  typedef enum logic [2:0] {
    stIdle, stSof, stSelect, stWait, stLoad, stSend, stNext, stDone
  } stateT;

  stateT             state, nextState;
  logic [IDX_W-1:0]  index, idxNext;
  logic [31:0]       shiftReg;
  logic [1:0]        byteCnt;
  logic              accept;

  logic [6:0]        ctrlNext;
  logic [7:0]        txDataNext;
  logic              txValidNext, busyNext, doneNext;

  // Code 22 is intentionally absent: that select has no latch behind it.
  function automatic logic [6:0] codeAt(input logic [IDX_W-1:0] i);
    case (i)
      5'd0:    codeAt = 7'h00;
      5'd1:    codeAt = 7'h01;
      5'd2:    codeAt = 7'h10;
      5'd3:    codeAt = 7'h11;
      5'd4:    codeAt = 7'h12;
      5'd5:    codeAt = 7'h13;
      5'd6:    codeAt = 7'h14;
      5'd7:    codeAt = 7'h15;
      5'd8:    codeAt = 7'h20;
      5'd9:    codeAt = 7'h21;
      5'd10:   codeAt = 7'h23;
      5'd11:   codeAt = 7'h24;
      5'd12:   codeAt = 7'h25;
      5'd13:   codeAt = 7'h26;
      5'd14:   codeAt = 7'h30;
      5'd15:   codeAt = 7'h31;
      5'd16:   codeAt = 7'h32;
      5'd17:   codeAt = 7'h33;
      5'd18:   codeAt = 7'h40;
      5'd19:   codeAt = 7'h41;
      default: codeAt = 7'h00;
    endcase
  endfunction

  assign accept = outTxValid && inTxReady;

  // State, index, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= stIdle;
      index      <= '0;
      shiftReg   <= '0;
      byteCnt    <= '0;
      outControl <= 7'h00;
      outTxData  <= 8'h00;
      outTxValid <= 1'b0;
      outBusy    <= 1'b0;
      outDone    <= 1'b0;
    end else begin
      state      <= nextState;
      index      <= idxNext;
      outControl <= ctrlNext;
      outTxData  <= txDataNext;
      outTxValid <= txValidNext;
      outBusy    <= busyNext;
      outDone    <= doneNext;
      if (state == stLoad) begin
        shiftReg <= inData;
        byteCnt  <= 2'd0;
      end else if (state == stSend && accept) begin
        shiftReg <= {shiftReg[23:0], 8'h00};
        byteCnt  <= byteCnt + 2'd1;
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      stIdle:   if (inStart) nextState = SEND_SOF ? stSof : stSelect;
      stSof:    if (accept) nextState = stSelect;
      stSelect: nextState = stWait;
      stWait:   nextState = stLoad;
      stLoad:   nextState = stSend;
      stSend:   if (accept && byteCnt == 2'd3) nextState = stNext;
      stNext:   nextState = (index == LAST_IDX) ? stDone : stSelect;
      stDone:   nextState = stIdle;
      default:  nextState = stIdle;
    endcase
  end

  // Next values of the output registers, keyed on the state being entered
  always_comb begin
    idxNext = index;
    if (state == stIdle || state == stDone)
      idxNext = '0;
    else if (state == stNext && index != LAST_IDX)
      idxNext = index + IDX_W'(1);

    ctrlNext   = outControl;
    txDataNext = outTxData;
    case (nextState)
      stIdle:   ctrlNext = 7'h00;
      stSelect: ctrlNext = codeAt(idxNext);
      stSof:    txDataNext = SOF_BYTE;
      stSend: begin
        if (state == stLoad)
          txDataNext = inData[31:24];
        else if (accept)
          txDataNext = shiftReg[23:16];
      end
      default: ;
    endcase

    txValidNext = (nextState == stSof) || (nextState == stSend);
    busyNext    = (nextState != stIdle);
    doneNext    = (nextState == stDone);
  end

endmodule
